fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning address/instruction width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the bubble instruction (addi x0,x0,0).
REQ-004 SHALL have port clk_i  input  1  meaning the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_ni  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port stall_i  input  1  meaning hold PC and the IF/ID register (load-use hazard).
REQ-007 SHALL have port flush_i  input  1  meaning replace the IF/ID contents with a bubble.
REQ-008 SHALL have port PCsrc_i  input  2  meaning next-PC select: 00 PC+4, 01 PCtarget_i, 10 ALUResult_i, 11 treated as 00.
REQ-009 SHALL have port PCtarget_i  input  DATA_WIDTH  meaning branch/JAL target.
REQ-010 SHALL have port ALUResult_i  input  DATA_WIDTH  meaning JALR target.
REQ-011 SHALL have port instr_i  input  DATA_WIDTH  meaning combinational instruction-memory read data for PC_o.
REQ-012 SHALL have port PC_o  output  DATA_WIDTH  meaning fetch address to instruction memory.
REQ-013 SHALL have port PC_D_o  output  DATA_WIDTH  meaning PC of the instruction held in IF/ID.
REQ-014 SHALL have port PCPlus4_D_o  output  DATA_WIDTH  meaning PC_D_o+4 (link value).
REQ-015 SHALL have port instr_D_o  output  DATA_WIDTH  meaning instruction presented to decode.
REQ-016 SHALL have port valid_D_o  output  1  meaning instr_D_o is a real fetched instruction, not a bubble.
REQ-017 SHALL have port misalign_o  output  1  meaning sticky flag: a misaligned redirect target was seen.

Function
REQ-018 PC_o SHALL be a register driven directly to the port (no combinational path from inputs).
REQ-019 Redirect: when PCsrc_i is 01 or 10, PC SHALL load the selected target on the next edge, regardless of stall_i.
REQ-020 For PCsrc_i=10 the target SHALL be ALUResult_i with bit 0 cleared before use.
REQ-021 No redirect and stall_i=1: PC SHALL hold.
REQ-022 No redirect and stall_i=0: PC SHALL load PC+4, wrapping modulo 2^DATA_WIDTH (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 A redirect target with bits [1:0] nonzero (after REQ-020) SHALL be loaded with bits [1:0] forced to 00 and SHALL set misalign_o, which stays 1 until reset.
REQ-024 IF/ID priority per edge: flush_i > stall_i > capture.
REQ-025 flush_i=1: instr_D_o SHALL become NOP_INSTR, valid_D_o 0, PC_D_o and PCPlus4_D_o 0.
REQ-026 stall_i=1 (no flush): IF/ID SHALL hold all fields.
REQ-027 Capture: instr_D_o<=instr_i, PC_D_o<=PC_o, PCPlus4_D_o<=PC_o+4 (wrapping), valid_D_o<=1.
REQ-028 Latency: instruction at address A SHALL appear on instr_D_o exactly one edge after PC_o=A when unstalled and unflushed.
REQ-029 Simultaneous redirect+stall+flush: PC SHALL take the target and IF/ID SHALL bubble in the same edge.

Reset
REQ-030 While rst_ni=0 (asynchronously, including mid-operation): PC_o=RESET_PC, instr_D_o=NOP_INSTR, valid_D_o=0, PC_D_o=0, PCPlus4_D_o=0, misalign_o=0.
REQ-031 First edge after rst_ni rises SHALL behave as a normal cycle from PC_o=RESET_PC.

Verification
REQ-032 Reset release, stall=flush=0, PCsrc=00, memory returns addr^32'hA5A5_0000 -> PC_o 0,4,8,...; instr_D_o lags one cycle, valid_D_o=1 from the second edge.
REQ-033 PC_o=0x10, PCsrc=01, PCtarget=0x40, flush=1 -> next PC_o=0x40, instr_D_o=0x0000_0013, valid_D_o=0; following cycle fetches 0x44.
REQ-034 PC_o=0x20, stall=1 for 2 cycles -> PC_o and IF/ID frozen 2 cycles; then PC_o=0x24.
REQ-035 PCsrc=10, ALUResult=0x103 -> PC_o=0x100, misalign_o=1 and stays 1 through later aligned jumps until rst_ni=0.
REQ-036 PC_o=32'hFFFF_FFFC, PCsrc=00 -> PC_o=0, PCPlus4_D_o=0 for the captured instruction.
REQ-037 rst_ni asserted mid-stall between clock edges -> outputs reach reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with redirect/stall handling and the
// IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = DATA_WIDTH'(32'h0000_0000),
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [1:0]            PCsrc_i,
  input  logic [DATA_WIDTH-1:0] PCtarget_i,
  input  logic [DATA_WIDTH-1:0] ALUResult_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] PC_D_o,
  output logic [DATA_WIDTH-1:0] PCPlus4_D_o,
  output logic [DATA_WIDTH-1:0] instr_D_o,
  output logic                  valid_D_o,
  output logic                  misalign_o
);

  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] pc_q, pc_d, pc_plus4, target;
  logic [DATA_WIDTH-1:0] pc_dec_q, pc_dec_d, pcp4_dec_q, pcp4_dec_d;
  logic [DATA_WIDTH-1:0] instr_dec_q, instr_dec_d;
  logic                  valid_q, valid_d, misalign_q, misalign_d, redirect;

  assign pc_plus4 = pc_q + FOUR;

  // Redirects win over stall so a taken branch is never lost behind a hazard.
  always_comb begin
    redirect = 1'b0;
    target   = pc_plus4;
    case (PCsrc_i)
      2'b01: begin
        redirect = 1'b1;
        target   = PCtarget_i;
      end
      2'b10: begin
        redirect = 1'b1;
        target   = {ALUResult_i[DATA_WIDTH-1:1], 1'b0};
      end
      default: begin
      end
    endcase

    misalign_d = misalign_q | (redirect & (|target[1:0]));

    if (redirect)     pc_d = {target[DATA_WIDTH-1:2], 2'b00};
    else if (stall_i) pc_d = pc_q;
    else              pc_d = pc_plus4;
  end

  always_comb begin
    pc_dec_d    = pc_dec_q;
    pcp4_dec_d  = pcp4_dec_q;
    instr_dec_d = instr_dec_q;
    valid_d     = valid_q;
    if (flush_i) begin
      pc_dec_d    = '0;
      pcp4_dec_d  = '0;
      instr_dec_d = NOP_INSTR;
      valid_d     = 1'b0;
    end else if (!stall_i) begin
      pc_dec_d    = pc_q;
      pcp4_dec_d  = pc_plus4;
      instr_dec_d = instr_i;
      valid_d     = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q        <= RESET_PC;
      pc_dec_q    <= '0;
      pcp4_dec_q  <= '0;
      instr_dec_q <= NOP_INSTR;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pc_dec_q    <= pc_dec_d;
      pcp4_dec_q  <= pcp4_dec_d;
      instr_dec_q <= instr_dec_d;
      valid_q     <= valid_d;
      misalign_q  <= misalign_d;
    end
  end

  assign PC_o        = pc_q;
  assign PC_D_o      = pc_dec_q;
  assign PCPlus4_D_o = pcp4_dec_q;
  assign instr_D_o   = instr_dec_q;
  assign valid_D_o   = valid_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle reference model compared on every
// falling edge, plus literal expectations at the scenario boundaries.
module tb_fetch_stage;

  localparam logic [31:0] MEM_XOR = 32'hA5A5_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic [1:0]  pcsrc = 2'b00;
  logic [31:0] pctarget = '0, aluresult = '0;
  logic [31:0] instr;
  logic [31:0] pc, pc_dec, pcp4_dec, instr_dec;
  logic        valid_dec, misalign;

  int passed = 0;
  int total  = 0;

  fetch_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .flush_i(flush),
    .PCsrc_i(pcsrc), .PCtarget_i(pctarget), .ALUResult_i(aluresult),
    .instr_i(instr), .PC_o(pc), .PC_D_o(pc_dec), .PCPlus4_D_o(pcp4_dec),
    .instr_D_o(instr_dec), .valid_D_o(valid_dec), .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  // Instruction memory: combinational, content derived from the address.
  assign instr = pc ^ MEM_XOR;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model
  logic [31:0] m_pc, m_pcd, m_pc4, m_instr;
  logic        m_valid, m_mis;
  logic [31:0] m_tgt;
  logic        m_redir;

  assign m_redir = (pcsrc == 2'd1) || (pcsrc == 2'd2);
  assign m_tgt   = (pcsrc == 2'd2) ? aluresult - (aluresult % 2) : pctarget;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 32'h0; m_pcd <= 32'h0; m_pc4 <= 32'h0;
      m_instr <= NOP; m_valid <= 1'b0; m_mis <= 1'b0;
    end else begin
      if (flush) begin
        m_pcd <= 32'h0; m_pc4 <= 32'h0; m_instr <= NOP; m_valid <= 1'b0;
      end else if (!stall) begin
        m_pcd <= m_pc; m_pc4 <= m_pc + 32'd4; m_instr <= m_pc ^ MEM_XOR; m_valid <= 1'b1;
      end
      if (m_redir) begin
        if (m_tgt % 4 != 0) m_mis <= 1'b1;
        m_pc <= m_tgt - (m_tgt % 4);
      end else if (!stall) begin
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    chk("PC_o", pc, m_pc);
    chk("PC_D_o", pc_dec, m_pcd);
    chk("PCPlus4_D_o", pcp4_dec, m_pc4);
    chk("instr_D_o", instr_dec, m_instr);
    chk("valid_D_o", {31'b0, valid_dec}, {31'b0, m_valid});
    chk("misalign_o", {31'b0, misalign}, {31'b0, m_mis});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu,
                       input logic st, input logic fl);
    pcsrc = src; pctarget = tgt; aluresult = alu; stall = st; flush = fl;
  endtask

  initial begin
    step(); step();
    chk("lit_reset_pc", pc, 32'h0);
    chk("lit_reset_instr", instr_dec, NOP);
    chk("lit_reset_valid", {31'b0, valid_dec}, 32'h0);
    rst_n = 1'b1;

    // sequential fetch from reset
    step();
    chk("lit_first_pc", pc, 32'h4);
    chk("lit_first_instr", instr_dec, 32'hA5A5_0000);
    chk("lit_first_valid", {31'b0, valid_dec}, 32'h1);
    step(); step();
    chk("lit_seq_pc", pc, 32'hC);
    chk("lit_seq_pcd", pc_dec, 32'h8);
    chk("lit_seq_pc4", pcp4_dec, 32'hC);
    step();

    // branch with flush at PC 0x10
    chk("lit_pc10", pc, 32'h10);
    drive(2'b01, 32'h40, 32'h0, 1'b0, 1'b1);
    step();
    chk("lit_br_pc", pc, 32'h40);
    chk("lit_br_instr", instr_dec, NOP);
    chk("lit_br_valid", {31'b0, valid_dec}, 32'h0);
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("lit_br_next", pc, 32'h44);
    chk("lit_br_next_instr", instr_dec, 32'hA5A5_0040);

    // two-cycle stall at 0x20
    drive(2'b01, 32'h20, 32'h0, 1'b0, 1'b0);
    step();
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    step(); step();
    chk("lit_stall_pc", pc, 32'h20);
    chk("lit_stall_pcd", pc_dec, 32'h44);
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("lit_unstall_pc", pc, 32'h24);
    chk("lit_unstall_pcd", pc_dec, 32'h20);

    // misaligned JALR, then sticky through aligned jumps
    drive(2'b10, 32'h0, 32'h103, 1'b0, 1'b0);
    step();
    chk("lit_jalr_pc", pc, 32'h100);
    chk("lit_jalr_mis", {31'b0, misalign}, 32'h1);
    drive(2'b01, 32'h200, 32'h0, 1'b0, 1'b0);
    step();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(2'b11, 32'h900, 32'h900, 1'b0, 1'b0);
    step();
    chk("lit_src11_pc", pc, 32'h208);
    chk("lit_sticky_mis", {31'b0, misalign}, 32'h1);

    // redirect under stall, then redirect+stall+flush together
    drive(2'b01, 32'h300, 32'h0, 1'b1, 1'b0);
    step();
    chk("lit_redir_stall_pc", pc, 32'h300);
    chk("lit_redir_stall_pcd", pc_dec, 32'h204);
    drive(2'b10, 32'h0, 32'h401, 1'b1, 1'b1);
    step();
    chk("lit_all_pc", pc, 32'h400);
    chk("lit_all_valid", {31'b0, valid_dec}, 32'h0);

    // wrap-around
    drive(2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
    step();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("lit_wrap_pc", pc, 32'h0);
    chk("lit_wrap_pcd", pc_dec, 32'hFFFF_FFFC);
    chk("lit_wrap_pc4", pcp4_dec, 32'h0);
    step(); step();

    // asynchronous reset in the middle of a stall
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_pc", pc, 32'h0);
    chk("lit_async_pcd", pc_dec, 32'h0);
    chk("lit_async_pc4", pcp4_dec, 32'h0);
    chk("lit_async_instr", instr_dec, NOP);
    chk("lit_async_valid", {31'b0, valid_dec}, 32'h0);
    chk("lit_async_mis", {31'b0, misalign}, 32'h0);
    step();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk("lit_rerun_pc", pc, 32'h4);

    // bit 0 cleared on JALR target is not a misalignment; bit 1 is
    drive(2'b10, 32'h0, 32'h101, 1'b0, 1'b0);
    step();
    chk("lit_jalr101_pc", pc, 32'h100);
    chk("lit_jalr101_mis", {31'b0, misalign}, 32'h0);
    drive(2'b01, 32'h6, 32'h0, 1'b0, 1'b0);
    step();
    chk("lit_br6_pc", pc, 32'h4);
    chk("lit_br6_mis", {31'b0, misalign}, 32'h1);
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    step(); step();

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
